cpu_id_seq: RTL and testbench
=============================

// Module: cpu_id_seq
// PURPOSE
//  Registered instruction-decode stage for the pipelined CPU generation. Decodes one instruction
//  word per accepted transfer into the datapath control bundle, with valid/ready handshakes on
//  both sides. Adds a hardware return-address stack for CALL/RET and a one-bubble Z interlock for
//  JZ/JZO. Sits between instruction fetch (IN side) and execute/write-back (OUT side).
// PARAMETERS
//  WIDTH           13  instruction word width
//  IWIDTH          5   opcode width; data field = WIDTH-IWIDTH (8)
//  REG_F_SEL_SIZE  4   register-file select width (R0-R7 + PORT)
//  IN_B_SEL_SIZE   2   ALU B-mux select: 00 IMM, 01 REG_F, 10 DATA_MEM
//  PC_WIDTH        8   program-counter width
//  STACK_DEPTH     4   return-stack entries, >=1; SLW = $clog2(STACK_DEPTH+1)
// PORTS
//  CLK             in   1            clock, rising edge
//  RST             in   1            async active-high reset
//  IN              in   WIDTH        instruction word
//  IN_VALID        in   1            IN/PC_IN valid
//  IN_READY        out  1            stage accepts IN this cycle
//  PC_IN           in   PC_WIDTH     address of instruction on IN
//  Z               in   1            ACC zero flag from execute
//  OUT_VALID       out  1            control bundle valid
//  OUT_READY       in   1            execute consumes bundle
//  PC_RST, PC_LD, EN_ACC, EN_REG_F, EN_D_MEM, D_MEM_ADDR_MODE, BASE_REG_LD  out 1 each
//  ALU_OUT         out  IWIDTH-1     ALU op = opcode[IWIDTH-2:0]
//  IMM, D_MEM_ADDR, BASE_REG_OFFSET, BASE_REG_DATA  out WIDTH-IWIDTH each
//  IN_B_SEL        out  IN_B_SEL_SIZE
//  REG_F_SEL       out  REG_F_SEL_SIZE
//  JMP_MODE        out  2            00 abs, 01 base-relative, 11 return
//  RET_ADDR        out  PC_WIDTH     popped return address (valid when JMP_MODE=11)
//  STACK_LEVEL     out  SLW          entries in use
//  ERR_OVF, ERR_UNF out 1            sticky stack overflow/underflow
//  ERR_CLR         in   1            synchronous clear of ERR_*
// BEHAVIOUR
//  Reset: OUT_VALID=0, ALU_OUT=all 1s (4'hF), IN_B_SEL=2'b10, all other bundle fields 0,
//   STACK_LEVEL=0, ERR_*=0. Reset mid-operation discards held bundle and stack contents.
//  Accept = IN_VALID & IN_READY. IN_READY = (!OUT_VALID | OUT_READY) & !stall.
//  Latency 1: bundle registered on accept edge; held stable while OUT_VALID & !OUT_READY.
//  OUT_VALID: set on accept; cleared on OUT_READY without new accept.
//  Decode (instr_set.v opcodes; unlisted fields take reset defaults):
//   RST: PC_RST=1, stack flushed (level 0). LD: D_MEM_ADDR=data, IN_B_SEL=10, EN_ACC.
//   ST: D_MEM_ADDR=data, EN_D_MEM. LDR/XORR/ORR/ANDR/ADDR/SUBR: REG_F_SEL=IN[3:0], IN_B_SEL=01,
//   EN_ACC. STR: REG_F_SEL=IN[3:0], EN_REG_F. BAR: BASE_REG_DATA=data, BASE_REG_LD.
//   JMP/JMPO: BASE_REG_OFFSET=data, JMP_MODE 00/01, PC_LD. NOT..INC: EN_ACC.
//   LDI: IMM=data, IN_B_SEL=00, EN_ACC. LDAR: REG_F_SEL=IN[3:0], D_MEM_ADDR_MODE=1, EN_ACC.
//   JZ/JZO: as JMP/JMPO only if Z=1 at accept, else NOP bundle. ALU_OUT=opcode[IWIDTH-2:0] for
//   all ALU/memory/register ops. Undefined opcode: NOP bundle (defaults), OUT_VALID still set.
//  Z interlock: stall=1 when IN is JZ/JZO and OUT_VALID & held EN_ACC=1 (ACC not yet updated).
//   Z sampled only on the accept edge.
//  CALL: PC_LD, JMP_MODE=00, BASE_REG_OFFSET=data; pushes PC_IN+1 (mod 2^PC_WIDTH), level+1.
//   Full (level=STACK_DEPTH): no push, ERR_OVF=1, NOP bundle emitted.
//  RET: pops top to RET_ADDR, JMP_MODE=11, PC_LD, level-1. Empty: ERR_UNF=1, NOP bundle.
//  Stack is LIFO; push/pop only on accept edge; one op per cycle, no push/pop conflict.
//  ERR_CLR with new error same cycle: error wins (stays 1).
// TESTING
//  LDI 0x5A, OUT_READY=1 -> next cycle OUT_VALID=1, IMM=8'h5A, IN_B_SEL=00, EN_ACC=1.
//  OUT_READY=0 for 3 cycles after ADD -> bundle stable, IN_READY=0, no second accept.
//  ADD then JZ 0x10, Z=1 after ADD commits -> one bubble (IN_READY=0), then PC_LD=1, offset 0x10.
//  CALL x5 from PC 0x20..0x24, DEPTH=4 -> levels 1..4, 5th: ERR_OVF=1, NOP; 4 RETs give 0x24..0x21.
//  RET at level 0 -> ERR_UNF=1, PC_LD=0; ERR_CLR -> 0. RST op at level 3 -> level 0.
//  Assert RST with OUT_VALID=1, level 2 -> OUT_VALID=0, ALU_OUT=4'hF, level 0 immediately.

Source files
------------

// File: rtl/cpu_id_seq.sv
// Registered instruction-decode stage: turns one instruction word per accepted transfer into the
// execute control bundle, with a hardware return-address stack and a one-bubble Z interlock.
module cpu_id_seq #(
   parameter int WIDTH          = 13,
   parameter int IWIDTH         = 5,
   parameter int REG_F_SEL_SIZE = 4,
   parameter int IN_B_SEL_SIZE  = 2,
   parameter int PC_WIDTH       = 8,
   parameter int STACK_DEPTH    = 4,
   localparam int DW            = WIDTH - IWIDTH,
   localparam int SLW           = $clog2(STACK_DEPTH + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [WIDTH-1:0]          in,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [PC_WIDTH-1:0]       pc_in,
   input  logic                      z,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      pc_rst,
   output logic                      pc_ld,
   output logic                      en_acc,
   output logic                      en_reg_f,
   output logic                      en_d_mem,
   output logic                      d_mem_addr_mode,
   output logic                      base_reg_ld,
   output logic [IWIDTH-2:0]         alu_out,
   output logic [DW-1:0]             imm,
   output logic [DW-1:0]             d_mem_addr,
   output logic [DW-1:0]             base_reg_offset,
   output logic [DW-1:0]             base_reg_data,
   output logic [IN_B_SEL_SIZE-1:0]  in_b_sel,
   output logic [REG_F_SEL_SIZE-1:0] reg_f_sel,
   output logic [1:0]                jmp_mode,
   output logic [PC_WIDTH-1:0]       ret_addr,
   output logic [SLW-1:0]            stack_level,
   output logic                      err_ovf,
   output logic                      err_unf,
   input  logic                      err_clr
);

   localparam logic [IWIDTH-1:0] OP_RST  = 5'h00, OP_LD   = 5'h01, OP_ST   = 5'h02,
                                 OP_LDR  = 5'h03, OP_STR  = 5'h04, OP_XORR = 5'h05,
                                 OP_ORR  = 5'h06, OP_ANDR = 5'h07, OP_ADDR = 5'h08,
                                 OP_SUBR = 5'h09, OP_NOT  = 5'h0A, OP_XOR  = 5'h0B,
                                 OP_OR   = 5'h0C, OP_AND  = 5'h0D, OP_ADD  = 5'h0E,
                                 OP_INC  = 5'h0F, OP_LDI  = 5'h10, OP_LDAR = 5'h11,
                                 OP_BAR  = 5'h12, OP_JMP  = 5'h13, OP_JMPO = 5'h14,
                                 OP_JZ   = 5'h15, OP_JZO  = 5'h16, OP_CALL = 5'h17,
                                 OP_RET  = 5'h18;

   logic [IWIDTH-1:0]         opcode;
   logic [DW-1:0]             data;
   logic                      stall, accept;
   logic [PC_WIDTH-1:0]       stack_mem [0:(1<<SLW)-1];
   logic [SLW-1:0]            top_idx;

   logic                      nx_pc_rst, nx_pc_ld, nx_en_acc, nx_en_reg_f, nx_en_d_mem;
   logic                      nx_d_mem_addr_mode, nx_base_reg_ld;
   logic [IWIDTH-2:0]         nx_alu;
   logic [DW-1:0]             nx_imm, nx_dma, nx_ofs, nx_brd;
   logic [IN_B_SEL_SIZE-1:0]  nx_bsel;
   logic [REG_F_SEL_SIZE-1:0] nx_rsel;
   logic [1:0]                nx_jmode;
   logic [PC_WIDTH-1:0]       nx_ret;
   logic                      do_push, do_pop, do_flush, set_ovf, set_unf;

   assign opcode   = in[WIDTH-1:DW];
   assign data     = in[DW-1:0];
   assign top_idx  = stack_level - SLW'(1);
   // A conditional jump must not sample Z while an ACC-writing bundle is still waiting in execute.
   assign stall    = (opcode == OP_JZ || opcode == OP_JZO) && out_valid && en_acc;
   assign in_ready = (!out_valid || out_ready) && !stall;
   assign accept   = in_valid && in_ready;

   always_comb begin
      nx_pc_rst = 1'b0;  nx_pc_ld = 1'b0;  nx_en_acc = 1'b0;  nx_en_reg_f = 1'b0;
      nx_en_d_mem = 1'b0;  nx_d_mem_addr_mode = 1'b0;  nx_base_reg_ld = 1'b0;
      nx_alu = '1;  nx_imm = '0;  nx_dma = '0;  nx_ofs = '0;  nx_brd = '0;
      nx_bsel = 2'b10;  nx_rsel = '0;  nx_jmode = 2'b00;  nx_ret = '0;
      do_push = 1'b0;  do_pop = 1'b0;  do_flush = 1'b0;  set_ovf = 1'b0;  set_unf = 1'b0;
      case (opcode)
         OP_RST: begin nx_pc_rst = 1'b1; do_flush = 1'b1; end
         OP_LD: begin
            nx_alu = opcode[IWIDTH-2:0]; nx_dma = data; nx_bsel = 2'b10; nx_en_acc = 1'b1;
         end
         OP_ST: begin nx_alu = opcode[IWIDTH-2:0]; nx_dma = data; nx_en_d_mem = 1'b1; end
         OP_LDR, OP_XORR, OP_ORR, OP_ANDR, OP_ADDR, OP_SUBR: begin
            nx_alu = opcode[IWIDTH-2:0]; nx_rsel = in[REG_F_SEL_SIZE-1:0];
            nx_bsel = 2'b01; nx_en_acc = 1'b1;
         end
         OP_STR: begin
            nx_alu = opcode[IWIDTH-2:0]; nx_rsel = in[REG_F_SEL_SIZE-1:0]; nx_en_reg_f = 1'b1;
         end
         OP_NOT, OP_XOR, OP_OR, OP_AND, OP_ADD, OP_INC: begin
            nx_alu = opcode[IWIDTH-2:0]; nx_en_acc = 1'b1;
         end
         OP_LDI: begin
            nx_alu = opcode[IWIDTH-2:0]; nx_imm = data; nx_bsel = 2'b00; nx_en_acc = 1'b1;
         end
         OP_LDAR: begin
            nx_alu = opcode[IWIDTH-2:0]; nx_rsel = in[REG_F_SEL_SIZE-1:0];
            nx_d_mem_addr_mode = 1'b1; nx_en_acc = 1'b1;
         end
         OP_BAR: begin nx_brd = data; nx_base_reg_ld = 1'b1; end
         OP_JMP, OP_JMPO: begin
            nx_ofs = data; nx_pc_ld = 1'b1; nx_jmode = (opcode == OP_JMPO) ? 2'b01 : 2'b00;
         end
         OP_JZ, OP_JZO: begin
            if (z) begin
               nx_ofs = data; nx_pc_ld = 1'b1; nx_jmode = (opcode == OP_JZO) ? 2'b01 : 2'b00;
            end
         end
         OP_CALL: begin
            if (stack_level == SLW'(STACK_DEPTH)) set_ovf = 1'b1;
            else begin do_push = 1'b1; nx_pc_ld = 1'b1; nx_ofs = data; end
         end
         OP_RET: begin
            if (stack_level == '0) set_unf = 1'b1;
            else begin
               do_pop = 1'b1; nx_pc_ld = 1'b1; nx_jmode = 2'b11; nx_ret = stack_mem[top_idx];
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         pc_rst <= 1'b0;  pc_ld <= 1'b0;  en_acc <= 1'b0;  en_reg_f <= 1'b0;  en_d_mem <= 1'b0;
         d_mem_addr_mode <= 1'b0;  base_reg_ld <= 1'b0;  alu_out <= '1;
         imm <= '0;  d_mem_addr <= '0;  base_reg_offset <= '0;  base_reg_data <= '0;
         in_b_sel <= 2'b10;  reg_f_sel <= '0;  jmp_mode <= 2'b00;  ret_addr <= '0;
         stack_level <= '0;  err_ovf <= 1'b0;  err_unf <= 1'b0;
         for (int i = 0; i < (1 << SLW); i++) stack_mem[i] <= '0;
      end else begin
         if (accept) begin
            out_valid <= 1'b1;
            pc_rst <= nx_pc_rst;  pc_ld <= nx_pc_ld;  en_acc <= nx_en_acc;
            en_reg_f <= nx_en_reg_f;  en_d_mem <= nx_en_d_mem;
            d_mem_addr_mode <= nx_d_mem_addr_mode;  base_reg_ld <= nx_base_reg_ld;
            alu_out <= nx_alu;  imm <= nx_imm;  d_mem_addr <= nx_dma;
            base_reg_offset <= nx_ofs;  base_reg_data <= nx_brd;  in_b_sel <= nx_bsel;
            reg_f_sel <= nx_rsel;  jmp_mode <= nx_jmode;  ret_addr <= nx_ret;
            if (do_push) begin
               stack_mem[stack_level] <= pc_in + PC_WIDTH'(1);
               stack_level <= stack_level + SLW'(1);
            end else if (do_pop) begin
               stack_level <= top_idx;
            end else if (do_flush) begin
               stack_level <= '0;
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         // A fresh error in the same cycle as a clear leaves the flag set.
         err_ovf <= (accept && set_ovf) || (err_ovf && !err_clr);
         err_unf <= (accept && set_unf) || (err_unf && !err_clr);
      end
   end

endmodule

// File: tb/tb_cpu_id_seq.sv
// Bench for cpu_id_seq: directed instruction sequences checked every cycle against a
// transaction-level model (stack as a queue), plus hand-computed literal expectations.
module tb_cpu_id_seq;

   localparam logic [4:0] OP_RST = 5'h00, OP_LD = 5'h01, OP_ST = 5'h02, OP_LDR = 5'h03,
                          OP_STR = 5'h04, OP_ADDR = 5'h08, OP_ADD = 5'h0E, OP_INC = 5'h0F,
                          OP_LDI = 5'h10, OP_LDAR = 5'h11, OP_BAR = 5'h12, OP_JMP = 5'h13,
                          OP_JMPO = 5'h14, OP_JZ = 5'h15, OP_JZO = 5'h16, OP_CALL = 5'h17,
                          OP_RET = 5'h18;
   localparam int SK_NONE = 0, SK_PUSH = 1, SK_POP = 2, SK_FLUSH = 3, SK_OVF = 4, SK_UNF = 5;

   typedef struct packed {
      logic       pc_rst, pc_ld, en_acc, en_reg_f, en_d_mem, d_mem_addr_mode, base_reg_ld;
      logic [3:0] alu;
      logic [7:0] imm, dma, ofs, brd;
      logic [1:0] bsel;
      logic [3:0] rsel;
      logic [1:0] jmode;
      logic [7:0] ret;
   } bundle_t;

   localparam logic [12:0] SWEEP [20] = '{
      13'h0111, 13'h0222, 13'h0303, 13'h0405, 13'h0501, 13'h060A, 13'h0707, 13'h0802,
      13'h090F, 13'h1299, 13'h1344, 13'h1455, 13'h0A00, 13'h0B12, 13'h0C34, 13'h0D56,
      13'h0F00, 13'h1106, 13'h1FAB, 13'h1666};

   logic        clk = 1'b0, rst = 1'b0;
   logic [12:0] in = '0;
   logic        in_valid = 1'b0, z = 1'b0, out_ready = 1'b0, err_clr = 1'b0;
   logic [7:0]  pc_in = '0;
   logic        in_ready, out_valid, pc_rst, pc_ld, en_acc, en_reg_f, en_d_mem;
   logic        d_mem_addr_mode, base_reg_ld, err_ovf, err_unf;
   logic [3:0]  alu_out, reg_f_sel;
   logic [7:0]  imm, d_mem_addr, base_reg_offset, base_reg_data, ret_addr;
   logic [1:0]  in_b_sel, jmp_mode;
   logic [2:0]  stack_level;
   bundle_t     dut_b;

   int          n_pass = 0, n_total = 0;
   bit          chk_en = 1'b0;

   bit          m_valid = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;
   bundle_t     m_b;
   logic [7:0]  m_stack [$];

   always #5 clk = ~clk;

   cpu_id_seq dut (
      .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .in_ready(in_ready),
      .pc_in(pc_in), .z(z), .out_valid(out_valid), .out_ready(out_ready),
      .pc_rst(pc_rst), .pc_ld(pc_ld), .en_acc(en_acc), .en_reg_f(en_reg_f),
      .en_d_mem(en_d_mem), .d_mem_addr_mode(d_mem_addr_mode), .base_reg_ld(base_reg_ld),
      .alu_out(alu_out), .imm(imm), .d_mem_addr(d_mem_addr),
      .base_reg_offset(base_reg_offset), .base_reg_data(base_reg_data),
      .in_b_sel(in_b_sel), .reg_f_sel(reg_f_sel), .jmp_mode(jmp_mode),
      .ret_addr(ret_addr), .stack_level(stack_level), .err_ovf(err_ovf),
      .err_unf(err_unf), .err_clr(err_clr));

   assign dut_b = {pc_rst, pc_ld, en_acc, en_reg_f, en_d_mem, d_mem_addr_mode, base_reg_ld,
                   alu_out, imm, d_mem_addr, base_reg_offset, base_reg_data, in_b_sel,
                   reg_f_sel, jmp_mode, ret_addr};

   function automatic bundle_t def_b();
      bundle_t b;
      b = '0;
      b.alu = 4'hF;
      b.bsel = 2'b10;
      return b;
   endfunction

   function automatic bundle_t model_decode(input logic [12:0] w, input logic zz, input int lvl,
                                            input logic [7:0] top, output int sk);
      bundle_t b;
      logic [4:0] op;
      logic [7:0] d;
      b = def_b(); op = w[12:8]; d = w[7:0]; sk = SK_NONE;
      if ((op >= OP_LD && op <= OP_INC) || op == OP_LDI || op == OP_LDAR) b.alu = op[3:0];
      if (op >= 5'h03 && op <= 5'h09 && op != OP_STR) begin
         b.rsel = d[3:0]; b.bsel = 2'b01; b.en_acc = 1'b1;
      end else if (op >= 5'h0A && op <= OP_INC) begin
         b.en_acc = 1'b1;
      end else begin
         case (op)
            OP_RST:  begin b.pc_rst = 1'b1; sk = SK_FLUSH; end
            OP_LD:   begin b.dma = d; b.en_acc = 1'b1; end
            OP_ST:   begin b.dma = d; b.en_d_mem = 1'b1; end
            OP_STR:  begin b.rsel = d[3:0]; b.en_reg_f = 1'b1; end
            OP_LDI:  begin b.imm = d; b.bsel = 2'b00; b.en_acc = 1'b1; end
            OP_LDAR: begin b.rsel = d[3:0]; b.d_mem_addr_mode = 1'b1; b.en_acc = 1'b1; end
            OP_BAR:  begin b.brd = d; b.base_reg_ld = 1'b1; end
            OP_JMP, OP_JMPO, OP_JZ, OP_JZO: begin
               if (op == OP_JMP || op == OP_JMPO || zz) begin
                  b.ofs = d; b.pc_ld = 1'b1;
                  b.jmode = (op == OP_JMPO || op == OP_JZO) ? 2'b01 : 2'b00;
               end
            end
            OP_CALL: begin
               if (lvl >= 4) sk = SK_OVF;
               else begin sk = SK_PUSH; b.pc_ld = 1'b1; b.ofs = d; end
            end
            OP_RET: begin
               if (lvl == 0) sk = SK_UNF;
               else begin sk = SK_POP; b.pc_ld = 1'b1; b.jmode = 2'b11; b.ret = top; end
            end
            default: ;
         endcase
      end
      return b;
   endfunction

   function automatic logic m_ready_f();
      logic is_jz;
      is_jz = (in[12:8] == OP_JZ) || (in[12:8] == OP_JZO);
      return (!m_valid || out_ready) && !(is_jz && m_valid && m_b.en_acc);
   endfunction

   always @(posedge clk or posedge rst) begin
      bit acc;
      int sk;
      bit new_ovf, new_unf;
      if (rst) begin
         m_valid = 1'b0; m_b = def_b(); m_stack.delete(); m_ovf = 1'b0; m_unf = 1'b0;
      end else begin
         acc = in_valid && m_ready_f();
         new_ovf = 1'b0; new_unf = 1'b0;
         if (acc) begin
            m_b = model_decode(in, z, m_stack.size(),
                               (m_stack.size() > 0) ? m_stack[$] : 8'h00, sk);
            m_valid = 1'b1;
            case (sk)
               SK_PUSH:  m_stack.push_back(pc_in + 8'd1);
               SK_POP:   void'(m_stack.pop_back());
               SK_FLUSH: m_stack.delete();
               SK_OVF:   new_ovf = 1'b1;
               SK_UNF:   new_unf = 1'b1;
               default: ;
            endcase
         end else if (out_ready) begin
            m_valid = 1'b0;
         end
         m_ovf = new_ovf || (m_ovf && !err_clr);
         m_unf = new_unf || (m_unf && !err_clr);
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("out_valid", 64'(out_valid), 64'(m_valid));
         check("in_ready", 64'(in_ready), 64'(m_ready_f()));
         check("stack_level", 64'(stack_level), 64'(m_stack.size()));
         check("err_ovf", 64'(err_ovf), 64'(m_ovf));
         check("err_unf", 64'(err_unf), 64'(m_unf));
         check("bundle", 64'(dut_b), 64'(m_b));
      end
   end

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [4:0] op, input logic [7:0] d, input logic [7:0] pc,
                       input logic zz, output int waited);
      bit got;
      got = 1'b0; waited = 0;
      in = {op, d}; pc_in = pc; z = zz; in_valid = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (in_ready) begin got = 1'b1; break; end
         waited++;
      end
      n_total++;
      if (got) n_pass++;
      else $display("FAIL accept_timeout: got no accept expected accept of op %0h", op);
      sync();
      in_valid = 1'b0;
   endtask

   initial begin
      int w;
      logic [12:0] wd;
      logic [7:0] ret_exp [4];
      ret_exp[0] = 8'h24; ret_exp[1] = 8'h23; ret_exp[2] = 8'h22; ret_exp[3] = 8'h21;

      #2 rst = 1'b1;
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_alu_out", 64'(alu_out), 64'(4'hF));
      check("rst_in_b_sel", 64'(in_b_sel), 64'(2'b10));
      check("rst_level", 64'(stack_level), 64'(0));
      sync();

      out_ready = 1'b1;
      send(OP_LDI, 8'h5A, 8'h00, 1'b0, w);
      @(negedge clk);
      check("ldi_valid", 64'(out_valid), 64'(1));
      check("ldi_imm", 64'(imm), 64'(8'h5A));
      check("ldi_bsel", 64'(in_b_sel), 64'(2'b00));
      check("ldi_en_acc", 64'(en_acc), 64'(1));
      sync();

      send(OP_ADD, 8'h00, 8'h01, 1'b0, w);
      out_ready = 1'b0;
      in = {OP_LDI, 8'h33}; in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("hold_in_ready", 64'(in_ready), 64'(0));
         check("hold_alu", 64'(alu_out), 64'(4'hE));
         check("hold_valid", 64'(out_valid), 64'(1));
      end
      sync();
      out_ready = 1'b1;
      send(OP_LDI, 8'h33, 8'h02, 1'b0, w);

      send(OP_ADD, 8'h00, 8'h03, 1'b0, w);
      send(OP_JZ, 8'h10, 8'h04, 1'b1, w);
      check("jz_bubble", 64'(w), 64'(1));
      @(negedge clk);
      check("jz_pc_ld", 64'(pc_ld), 64'(1));
      check("jz_offset", 64'(base_reg_offset), 64'(8'h10));
      sync();
      send(OP_JZ, 8'h11, 8'h05, 1'b0, w);
      @(negedge clk);
      check("jz_not_taken", 64'(pc_ld), 64'(0));
      sync();
      send(OP_JZO, 8'h12, 8'h06, 1'b1, w);

      for (int i = 0; i < 5; i++) send(OP_CALL, 8'h40, 8'(8'h20 + i), 1'b0, w);
      @(negedge clk);
      check("ovf_flag", 64'(err_ovf), 64'(1));
      check("ovf_nop", 64'(pc_ld), 64'(0));
      check("ovf_level", 64'(stack_level), 64'(4));
      sync();
      for (int i = 0; i < 4; i++) begin
         send(OP_RET, 8'h00, 8'h60, 1'b0, w);
         @(negedge clk);
         check("ret_addr", 64'(ret_addr), 64'(ret_exp[i]));
         check("ret_mode", 64'(jmp_mode), 64'(2'b11));
         sync();
      end
      err_clr = 1'b1;
      sync();
      err_clr = 1'b0;
      @(negedge clk);
      check("ovf_cleared", 64'(err_ovf), 64'(0));
      sync();

      send(OP_RET, 8'h00, 8'h61, 1'b0, w);
      @(negedge clk);
      check("unf_flag", 64'(err_unf), 64'(1));
      check("unf_pc_ld", 64'(pc_ld), 64'(0));
      sync();
      err_clr = 1'b1;
      sync();
      err_clr = 1'b0;
      @(negedge clk);
      check("unf_cleared", 64'(err_unf), 64'(0));
      sync();
      err_clr = 1'b1;
      send(OP_RET, 8'h00, 8'h62, 1'b0, w);
      err_clr = 1'b0;
      @(negedge clk);
      check("err_wins", 64'(err_unf), 64'(1));
      sync();
      err_clr = 1'b1;
      sync();
      err_clr = 1'b0;

      for (int i = 0; i < 3; i++) send(OP_CALL, 8'h50, 8'(8'h70 + i), 1'b0, w);
      send(OP_RST, 8'h00, 8'h73, 1'b0, w);
      @(negedge clk);
      check("rstop_level", 64'(stack_level), 64'(0));
      check("rstop_pc_rst", 64'(pc_rst), 64'(1));
      sync();

      for (int i = 0; i < 20; i++) begin
         wd = SWEEP[i];
         send(wd[12:8], wd[7:0], 8'(i), 1'(i % 2), w);
      end

      send(OP_CALL, 8'h01, 8'h80, 1'b0, w);
      send(OP_CALL, 8'h02, 8'h81, 1'b0, w);
      out_ready = 1'b0;
      @(negedge clk);
      check("pre_rst_valid", 64'(out_valid), 64'(1));
      check("pre_rst_level", 64'(stack_level), 64'(2));
      sync();
      rst = 1'b1;
      #1;
      check("async_valid", 64'(out_valid), 64'(0));
      check("async_alu", 64'(alu_out), 64'(4'hF));
      check("async_level", 64'(stack_level), 64'(0));
      sync();
      rst = 1'b0;
      out_ready = 1'b1;
      send(OP_LD, 8'h77, 8'h90, 1'b0, w);
      send(OP_ST, 8'h78, 8'h91, 1'b0, w);
      repeat (2) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
